// File: rtl/lii_tx_packer_pkg.sv
// lii_tx_packer_pkg: shared LII constants and ID type used by transmit-side wrappers
package lii_tx_packer_pkg;
    localparam int LII_ID_W = 8;
    localparam int LII_PW = 1024;
    typedef logic [LII_ID_W-1:0] lii_id_t;
endpackage

// File: rtl/lii_tx_packer_out_reg.sv
// lii_out_reg: one-entry valid/ready output register; data is held while stalled
module lii_out_reg
    import lii_tx_packer_pkg::*;
#(
    parameter int W = LII_PW
) (
    input  logic         aclk,
    input  logic         arst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         free,
    output logic [W-1:0] tdata,
    output logic         tvalid,
    input  logic         tready
);
    assign free = !tvalid || tready;

    always_ff @(posedge aclk) begin
        if (arst) begin
            tdata  <= '0;
            tvalid <= 1'b0;
        end else if (load) begin
            tdata  <= load_data;
            tvalid <= 1'b1;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end
endmodule

// File: rtl/lii_tx_packer.sv
// lii_tx_packer: packs PW/DW kernel beats into one LII word, flushing early on tlast or idle timeout
module lii_tx_packer
    import lii_tx_packer_pkg::*;
#(
    parameter int      DW           = 192,
    parameter int      PW           = LII_PW,
    parameter lii_id_t SRC_ID       = 8'd0,
    parameter lii_id_t DST_ID       = 8'd1,
    parameter int      IDLE_TIMEOUT = 16
) (
    input  logic                        aclk,
    input  logic                        arst,
    input  logic [DW-1:0]               s_tdata,
    input  logic                        s_tvalid,
    output logic                        s_tready,
    input  logic                        s_tlast,
    output logic [PW-1:0]               lii_out_p0_tdata,
    output logic                        lii_out_p0_tvalid,
    input  logic                        lii_out_p0_tready,
    output lii_id_t                     lii_out_p0_src,
    output lii_id_t                     lii_out_p0_dst,
    output logic [$clog2(PW/DW+1)-1:0]  occupancy
);
    localparam int N  = PW / DW;
    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 2);

    logic [CW-1:0] cnt;
    logic [IW-1:0] idle;
    logic [PW-1:0] acc, merged;
    logic          free, accept, complete, timeout;

    assign s_tready       = free;
    assign accept         = s_tvalid && free;
    assign complete       = accept && (cnt == CW'(N - 1) || s_tlast);
    // A beat in the same cycle always beats the timeout; cnt == 0 never flushes
    assign timeout        = IDLE_TIMEOUT > 0 && cnt != '0 && !accept && free && idle == IW'(IDLE_TIMEOUT);
    assign lii_out_p0_src = SRC_ID;
    assign lii_out_p0_dst = DST_ID;
    assign occupancy      = cnt;

    always_comb begin
        merged = acc;
        merged[int'(cnt)*DW +: DW] = s_tdata;
    end

    always_ff @(posedge aclk) begin
        if (arst || complete || timeout) begin
            acc  <= '0;
            cnt  <= '0;
            idle <= '0;
        end else if (accept) begin
            acc  <= merged;
            cnt  <= cnt + 1'b1;
            idle <= '0;
        end else if (cnt != '0 && idle != IW'(IDLE_TIMEOUT)) begin
            idle <= idle + 1'b1;
        end
    end

    lii_out_reg #(.W(PW)) u_out (
        .aclk      (aclk),
        .arst      (arst),
        .load      (complete || timeout),
        .load_data (complete ? merged : acc),
        .free      (free),
        .tdata     (lii_out_p0_tdata),
        .tvalid    (lii_out_p0_tvalid),
        .tready    (lii_out_p0_tready)
    );
endmodule

// File: doc/lii_tx_packer.md
Name: lii_tx_packer

Overview:
- Transmit-side adapter between a narrow HLS kernel output stream and one LII phy output channel.
- Accumulates N = PW/DW kernel beats into one PW-bit LII word, tagging it with constant src/dst IDs.
- Emits partial words early on s_tlast or on an idle timeout.
- Sits between a kernel's out_stream and the LII fabric. It is the packing counterpart to the wrappers that unpack LII words into kernel input streams.

Parameters:
- DW, 192, kernel beat width.
- PW, 1024, LII packing width; N = PW/DW localparam (5 at defaults); PW >= DW required.
- SRC_ID, 8'd0, value driven on lii_out_p0_src.
- DST_ID, 8'd1, value driven on lii_out_p0_dst.
- IDLE_TIMEOUT, 16, idle cycles before a partial word is flushed; 0 disables the timeout.

Ports:
- aclk  in  1  clock.
- arst  in  1  synchronous active-high reset.
- s_tdata  in  DW  kernel beat.
- s_tvalid  in  1  kernel beat valid.
- s_tready  out  1  packer ready for a beat.
- s_tlast  in  1  end of kernel message; forces a flush after this beat.
- lii_out_p0_tdata  out  PW  packed word.
- lii_out_p0_tvalid  out  1  word valid.
- lii_out_p0_tready  in  1  fabric ready.
- lii_out_p0_src  out  8  constant SRC_ID.
- lii_out_p0_dst  out  8  constant DST_ID.
- occupancy  out  $clog2(N+1)  beats currently held in the accumulator.

Behaviour:
- One clock (aclk). Reset (arst) is synchronous and active-high.
- Reset values:
  - accumulator all zero; slot count cnt = 0; idle counter = 0.
  - lii_out_p0_tvalid = 0; lii_out_p0_tdata = 0; occupancy = 0.
  - s_tready = 1 in the first cycle after reset.
- Reset mid-operation discards any partial accumulator and any pending output word.
- Storage: accumulator acc[PW], cnt in 0..N-1, one-entry output register (data + valid).
- Acceptance: beat is accepted when s_tvalid && s_tready.
- s_tready = !lii_out_p0_tvalid || lii_out_p0_tready. This is combinational from the output register and tready only, and does not depend on s_tvalid.
- Placement: an accepted beat is written to acc[cnt*DW +: DW]; cnt increments.
- Word completion on an accepted beat when cnt == N-1 or s_tlast == 1:
  - Output register loads acc merged with the new beat; all bits at or above (cnt+1)*DW are zero.
  - lii_out_p0_tvalid = 1 on the next cycle.
  - acc is cleared, cnt = 0, idle counter = 0.
- Latency: the word is visible one cycle after the completing beat's handshake.
- Output handshake: tdata is held stable while tvalid && !tready. tvalid drops after the handshake unless a new word is loaded in the same cycle (back-to-back allowed: 1 word per N cycles at full rate).
- Idle timeout (IDLE_TIMEOUT > 0):
  - The idle counter increments each cycle with cnt > 0 and no accepted beat; it resets to 0 on any accepted beat.
  - When it reaches IDLE_TIMEOUT and the output register is free or draining this cycle, acc is flushed as a partial word (same zero-padding rule); cnt = 0 and the counter = 0.
  - If the output register is blocked, the counter saturates at IDLE_TIMEOUT and the flush waits.
- Simultaneous events:
  - An accepted beat in the same cycle as a timeout wins: no flush, beat appended, counter reset.
  - s_tlast with cnt == N-1 emits a single full word.
- s_tlast with cnt == 0 emits a word containing only that beat in slot 0.
- cnt == 0 never flushes: no empty words are ever emitted.
- src/dst are constant wires equal to SRC_ID/DST_ID, valid in every cycle including reset.
- occupancy = cnt (registered).

Decomposition:
- Shared LII package: ID width constant (8), lii_id_t typedef, and default PW constant (1024).
- Natural sub-module: lii_out_reg, a one-entry output register with valid/ready holding data, valid, and the stall/load logic. It is reusable by other LII transmit wrappers.
- Accumulator, slot counter and timeout live in the top.

Test Plan:
- Full packing: 5 beats 0x1..0x5 with no backpressure, s_tlast on beat 5 -> one word with slots 0..4 = 1..5, bits [1023:960] = 0, src 0x00, dst 0x01, tvalid one cycle after beat 5.
- Early tlast: 2 beats 0xA, 0xB, tlast on 0xB -> word with slot0 = 0xA, slot1 = 0xB, bits [1023:384] = 0; next beat lands in slot 0.
- Timeout flush: 3 beats then s_tvalid = 0 for 20 cycles with IDLE_TIMEOUT = 16 -> partial word emitted after exactly 16 idle cycles, occupancy returns to 0. With IDLE_TIMEOUT = 0, no word is emitted.
- Backpressure: 10 beats streaming with lii_out_p0_tready = 0 -> first word held stable, s_tready low from the cycle tvalid rises. Release tready -> words 1..5 then 6..10, no loss or duplication.
- Timeout vs beat collision: beat arrives in the cycle the idle counter hits IDLE_TIMEOUT -> no flush, beat goes to the next slot.
- Reset mid-word: 2 beats accepted, arst pulsed 1 cycle -> tvalid = 0, occupancy = 0, the next 5 beats form a clean word starting in slot 0.
